// File: rtl/instr_issue_seq_if.sv
// Opcode handshake bus between the issue sequencer (master) and the
// datapath (slave).
interface instr_issue_seq_if #(
    parameter int DW = 16
);
    logic [DW-1:0] opcode;
    logic          opcode_valid;
    logic          opcode_ready;

    modport master (output opcode, output opcode_valid, input opcode_ready);
    modport slave  (input opcode, input opcode_valid, output opcode_ready);
endinterface

// File: rtl/instr_issue_seq.sv
// Instruction fetch/issue sequencer. Holds a loadable instruction memory,
// walks pc from start_addr to end_addr (wrapping mod 2**AW) and presents
// each word on the opcode handshake, with one fetch bubble per word.
// Runs end at end_addr, on a HALT word, or on a stop request.
// Optional feature macro: ISSUE_LOOP_EN adds a loop_en input; when latched
// on start, end_addr jumps back to start_addr instead of finishing.
module instr_issue_seq #(
    parameter int         DW      = 16,
    parameter int         AW      = 8,
    parameter logic [2:0] HALT_OP = 3'b111
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load_en,
    input  logic [AW-1:0] load_addr,
    input  logic [DW-1:0] load_data,
    input  logic          start,
    input  logic          stop,
    input  logic [AW-1:0] start_addr,
    input  logic [AW-1:0] end_addr,
`ifdef ISSUE_LOOP_EN
    input  logic          loop_en,
`endif
    instr_issue_seq_if.master issue,
    output logic [AW-1:0] pc,
    output logic          busy,
    output logic          done,
    output logic          halted
);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_ISSUE, S_DONE} state_t;

    state_t        state, state_nxt;
    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic [AW-1:0] end_q;
    logic          stop_pend;
    logic          accept, hs, is_halt, last, loop_back;
    logic [AW-1:0] pc_nxt;

    assign accept  = ((state == S_IDLE) || (state == S_DONE)) && start;
    assign hs      = (state == S_ISSUE) && issue.opcode_valid && issue.opcode_ready;
    assign is_halt = (issue.opcode[DW-1 -: 3] == HALT_OP);
    assign last    = (pc == end_q);

`ifdef ISSUE_LOOP_EN
    logic          loop_q;
    logic [AW-1:0] start_q;

    // Loop mode and restart address are captured with the run parameters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            loop_q  <= 1'b0;
            start_q <= '0;
        end else if (accept) begin
            loop_q  <= loop_en;
            start_q <= start_addr;
        end
    end

    assign loop_back = loop_q && last;
    assign pc_nxt    = loop_back ? start_q : pc + AW'(1);
`else
    assign loop_back = 1'b0;
    assign pc_nxt    = pc + AW'(1);
`endif

    // Instruction memory write port; locked out while a program runs
    always_ff @(posedge clk) begin
        if (load_en && !busy)
            mem[load_addr] <= load_data;
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic; a delivered HALT word, a pending stop or the end of
    // range (unless looping) all retire the run after the handshake
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_FETCH;
            S_FETCH: state_nxt = stop ? S_DONE : S_ISSUE;
            S_ISSUE: begin
                if (hs) begin
                    if (is_halt || stop || stop_pend || (last && !loop_back))
                        state_nxt = S_DONE;
                    else
                        state_nxt = S_FETCH;
                end
            end
            S_DONE:  state_nxt = start ? S_FETCH : S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Status outputs decoded from state; DONE lasts exactly one cycle
    always_comb begin
        busy = (state == S_FETCH) || (state == S_ISSUE);
        done = (state == S_DONE);
    end

    // Datapath: run parameters, pc, the opcode register (loaded straight from
    // the synchronous memory read in FETCH) and the sticky halt flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issue.opcode       <= '0;
            issue.opcode_valid <= 1'b0;
            pc                 <= '0;
            halted             <= 1'b0;
            end_q              <= '0;
            stop_pend          <= 1'b0;
        end else begin
            if (accept) begin
                end_q     <= end_addr;
                pc        <= start_addr;
                halted    <= 1'b0;
                stop_pend <= 1'b0;
            end
            if ((state == S_FETCH) && !stop) begin
                issue.opcode       <= mem[pc];
                issue.opcode_valid <= 1'b1;
            end
            if (state == S_ISSUE) begin
                if (stop)
                    stop_pend <= 1'b1;
                if (hs) begin
                    issue.opcode_valid <= 1'b0;
                    if (is_halt)
                        halted <= 1'b1;
                    if (state_nxt == S_FETCH)
                        pc <= pc_nxt;
                end
            end
        end
    end

endmodule

// File: tb/tb_instr_issue_seq.sv
// Bench for instr_issue_seq: directed program runs with literal expectations
// plus a randomized phase, all checked every cycle against a behavioural model.
module tb_instr_issue_seq;
    localparam int DW = 16;
    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          load_en = 1'b0;
    logic [AW-1:0] load_addr = '0;
    logic [DW-1:0] load_data = '0;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic [AW-1:0] start_addr = '0;
    logic [AW-1:0] end_addr = '0;
    logic [AW-1:0] pc;
    logic          busy, done, halted;
`ifdef ISSUE_LOOP_EN
    logic          loop_en = 1'b0;
`endif

    instr_issue_seq_if #(.DW(DW)) bus ();

    instr_issue_seq #(.DW(DW), .AW(AW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_en    (load_en),
        .load_addr  (load_addr),
        .load_data  (load_data),
        .start      (start),
        .stop       (stop),
        .start_addr (start_addr),
        .end_addr   (end_addr),
`ifdef ISSUE_LOOP_EN
        .loop_en    (loop_en),
`endif
        .issue      (bus),
        .pc         (pc),
        .busy       (busy),
        .done       (done),
        .halted     (halted)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [DW-1:0] mem_m [0:255];
    logic          m_busy = 0, m_valid = 0, m_done = 0, m_halted = 0, m_loop = 0, m_pend = 0;
    logic [DW-1:0] m_op = '0;
    logic [AW-1:0] m_pc = '0, m_end = '0, m_start = '0;
    bit            fin;

    initial begin
        for (int i = 0; i < 256; i++) mem_m[i] = '0;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_busy = 0; m_valid = 0; m_done = 0; m_halted = 0;
                m_op = '0; m_pc = '0; m_pend = 0;
            end else begin
                fin = 0;
                if (!m_busy) begin
                    if (load_en) mem_m[load_addr] = load_data;
                    if (start) begin
                        m_busy = 1; m_valid = 0; m_pend = 0; m_halted = 0;
                        m_pc = start_addr; m_start = start_addr; m_end = end_addr;
`ifdef ISSUE_LOOP_EN
                        m_loop = loop_en;
`else
                        m_loop = 0;
`endif
                    end
                end else if (!m_valid) begin
                    // fetch bubble: either the word appears or stop aborts
                    if (stop) fin = 1;
                    else begin
                        m_valid = 1;
                        m_op = mem_m[m_pc];
                    end
                end else begin
                    if (stop) m_pend = 1;
                    if (bus.opcode_ready) begin
                        m_valid = 0;
                        if (m_op[15:13] == 3'b111) begin
                            m_halted = 1;
                            fin = 1;
                        end else if (m_pend || (m_pc == m_end && !m_loop))
                            fin = 1;
                        else if (m_pc == m_end)
                            m_pc = m_start;
                        else
                            m_pc = m_pc + 1;
                    end
                end
                m_done = fin;
                if (fin) begin m_busy = 0; m_valid = 0; end
            end
        end
    end

    // ---------------- compare / monitor ----------------
    logic [DW-1:0] seen_op [$];
    logic [AW-1:0] seen_pc [$];
    int            seen_cyc [$];
    int            done_cnt = 0, first_valid = -1, cnt_2081 = 0, start_cyc = 0;

    initial forever begin
        @(negedge clk);
        chk("valid",  {31'b0, bus.opcode_valid}, {31'b0, m_valid});
        chk("opcode", {16'b0, bus.opcode}, {16'b0, m_op});
        chk("pc",     {24'b0, pc}, {24'b0, m_pc});
        chk("busy",   {31'b0, busy}, {31'b0, m_busy});
        chk("done",   {31'b0, done}, {31'b0, m_done});
        chk("halted", {31'b0, halted}, {31'b0, m_halted});
        if (bus.opcode_valid && first_valid < 0) first_valid = cyc;
        if (bus.opcode_valid && bus.opcode_ready) begin
            seen_op.push_back(bus.opcode);
            seen_pc.push_back(pc);
            seen_cyc.push_back(cyc);
        end
        if (bus.opcode_valid && bus.opcode == 16'h2081) cnt_2081++;
        if (done) done_cnt++;
    end

    // ---------------- stimulus helpers ----------------
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [AW-1:0] a, input logic [DW-1:0] d);
        load_en = 1; load_addr = a; load_data = d;
        cycle();
        load_en = 0;
    endtask

    task automatic run(input logic [AW-1:0] sa, input logic [AW-1:0] ea,
                       input int stall_word, input int stall_n, input int stop_word,
                       input bit busy_load);
        int  stalled;
        bit  stopped;
        stalled = 0; stopped = 0;
        seen_op.delete(); seen_pc.delete(); seen_cyc.delete();
        done_cnt = 0; first_valid = -1; cnt_2081 = 0;
        start_addr = sa; end_addr = ea; start = 1; start_cyc = cyc;
        cycle();
        start = 0;
        for (int k = 0; k < 300 && done_cnt == 0; k++) begin
            bus.opcode_ready = 1; stop = 0; load_en = 0;
            if (busy_load && k == 0) begin
                load_en = 1; load_addr = 8'd3; load_data = 16'hFFFF;
            end
            if (bus.opcode_valid && seen_op.size() == stall_word && stalled < stall_n) begin
                bus.opcode_ready = 0; stalled++;
            end
            if (bus.opcode_valid && seen_op.size() == stop_word && !stopped) begin
                stop = 1; stopped = 1;
            end
            cycle();
        end
        stop = 0; load_en = 0; bus.opcode_ready = 1;
        if (done_cnt == 0) chk("run_timeout", 32'd0, 32'd1);
        cycle();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [AW-1:0] sa;
        bus.opcode_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        // reset state
        chk("rst_valid",  {31'b0, bus.opcode_valid}, 32'd0);
        chk("rst_opcode", {16'b0, bus.opcode}, 32'd0);
        chk("rst_pc",     {24'b0, pc}, 32'd0);
        chk("rst_busy",   {31'b0, busy}, 32'd0);
        chk("rst_done",   {31'b0, done}, 32'd0);
        chk("rst_halted", {31'b0, halted}, 32'd0);

        for (int a = 0; a < 256; a++) load(a[AW-1:0], DW'($urandom));
        load(8'd0, 16'h0140); load(8'd1, 16'h2081); load(8'd2, 16'h4081); load(8'd3, 16'h60A0);

        // basic program, ready high
        run(8'd0, 8'd3, -1, 0, -1, 0);
        chk("t1_count", seen_op.size(), 32'd4);
        if (seen_op.size() == 4) begin
            chk("t1_w0", {16'b0, seen_op[0]}, 32'h0140);
            chk("t1_w1", {16'b0, seen_op[1]}, 32'h2081);
            chk("t1_w2", {16'b0, seen_op[2]}, 32'h4081);
            chk("t1_w3", {16'b0, seen_op[3]}, 32'h60A0);
            chk("t1_rate", seen_cyc[1] - seen_cyc[0], 32'd2);
        end
        chk("t1_latency", first_valid - start_cyc, 32'd2);
        chk("t1_done", done_cnt, 32'd1);
        chk("t1_pc", {24'b0, pc}, 32'd3);
        chk("t1_halted", {31'b0, halted}, 32'd0);

        // backpressure on word 1
        run(8'd0, 8'd3, 1, 3, -1, 0);
        chk("t2_count", seen_op.size(), 32'd4);
        chk("t2_hold", cnt_2081, 32'd4);
        if (seen_op.size() == 4) chk("t2_w2", {16'b0, seen_op[2]}, 32'h4081);

        // HALT word
        load(8'd1, 16'hE000);
        run(8'd0, 8'd3, -1, 0, -1, 0);
        chk("t3_count", seen_op.size(), 32'd2);
        if (seen_op.size() == 2) chk("t3_w1", {16'b0, seen_op[1]}, 32'hE000);
        chk("t3_halted", {31'b0, halted}, 32'd1);
        chk("t3_done", done_cnt, 32'd1);
        load(8'd1, 16'h2081);

        // wrap-around range
        load(8'd254, 16'h1111); load(8'd255, 16'h1222);
        run(8'd254, 8'd1, -1, 0, -1, 0);
        chk("t4_count", seen_pc.size(), 32'd4);
        if (seen_pc.size() == 4) begin
            chk("t4_pc0", {24'b0, seen_pc[0]}, 32'd254);
            chk("t4_pc1", {24'b0, seen_pc[1]}, 32'd255);
            chk("t4_pc2", {24'b0, seen_pc[2]}, 32'd0);
            chk("t4_pc3", {24'b0, seen_pc[3]}, 32'd1);
        end

        // stop while word 1 is stalled, plus a write attempt while busy
        run(8'd0, 8'd3, 1, 2, 1, 1);
        chk("t5_count", seen_op.size(), 32'd2);
        if (seen_op.size() == 2) chk("t5_w1", {16'b0, seen_op[1]}, 32'h2081);
        chk("t5_done", done_cnt, 32'd1);
        run(8'd3, 8'd3, -1, 0, -1, 0);
        chk("t5_single", seen_op.size(), 32'd1);
        if (seen_op.size() == 1) chk("t5_mem3", {16'b0, seen_op[0]}, 32'h60A0);

        // asynchronous reset in the middle of a stalled handshake
        start_addr = 8'd2; end_addr = 8'd3; start = 1;
        cycle();
        start = 0; bus.opcode_ready = 0;
        cycle();
        chk("t6_pre_valid", {31'b0, bus.opcode_valid}, 32'd1);
        done_cnt = 0;
        #2 rst_n = 0;
        #1;
        chk("t6_valid", {31'b0, bus.opcode_valid}, 32'd0);
        chk("t6_pc",    {24'b0, pc}, 32'd0);
        chk("t6_busy",  {31'b0, busy}, 32'd0);
        cycle(); cycle();
        rst_n = 1; bus.opcode_ready = 1;
        repeat (3) cycle();
        chk("t6_no_done", done_cnt, 32'd0);

`ifdef ISSUE_LOOP_EN
        loop_en = 1;
        run(8'd0, 8'd1, -1, 0, 6, 0);
        loop_en = 0;
        chk("t7_count", seen_pc.size(), 32'd7);
        for (int i = 0; i < seen_pc.size() && i < 7; i++)
            chk("t7_pc", {24'b0, seen_pc[i]}, i % 2);
        chk("t7_done", done_cnt, 32'd1);
`endif

        // randomized phase
        for (int i = 0; i < 1500; i++) begin
            bus.opcode_ready = ($urandom_range(0, 9) < 7);
            stop = ($urandom_range(0, 29) == 0);
            start = 0; load_en = 0;
            if ($urandom_range(0, 3) == 0) begin
                load_en = 1; load_addr = AW'($urandom); load_data = DW'($urandom);
            end
            if ($urandom_range(0, 5) == 0) begin
                start = 1;
                sa = AW'($urandom);
                start_addr = sa;
                end_addr = sa + AW'($urandom_range(0, 6));
`ifdef ISSUE_LOOP_EN
                loop_en = ($urandom_range(0, 3) == 0);
`endif
            end
            cycle();
        end
        start = 0; load_en = 0; stop = 1; bus.opcode_ready = 1;
        for (int i = 0; i < 50 && busy; i++) cycle();
        stop = 0;
        chk("final_idle", {31'b0, busy}, 32'd0);
        cycle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
